// File: rtl/uart_vga_pkg.sv
// Shared types and constants for the UART-fed VGA frame buffer.
package uart_vga_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         VIS_W     = 640;
  localparam int         VIS_H     = 480;
  localparam int         COLOUR_W  = 12;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HI,
    WAIT_LO
  } ufb_state_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Vertical colour bar: each bar index bit drives one full colour channel.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    c.r = {4{idx[2]}};
    c.g = {4{idx[1]}};
    c.b = {4{idx[0]}};
    return c;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one write port, one read-first synchronous read port, 1-cycle read.
module frame_ram #(
  parameter int DEPTH = 19200,
  parameter int AW    = 15,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;

  // Read samples the array before this edge's write lands, so a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
    rd_q <= mem[rd_addr];
  end

  assign rd_dat = rd_q;

endmodule

// File: rtl/uart_frame_buffer.sv
// UART byte stream -> downscaled frame store -> raster colour, 1-cycle read latency, no backpressure.
// Optional UFB_TEST_PATTERN_EN shows colour bars until the first complete frame after reset.
module uart_frame_buffer
  import uart_vga_pkg::*;
#(
  parameter int H_PIX       = 160,
  parameter int V_PIX       = 120,
  parameter int SCALE_SHIFT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic [9:0]          h_count,
  input  logic [9:0]          v_count,
  output logic [COLOUR_W-1:0] rgb_colour,
  output logic                busy,
  output logic                frame_done,
  output logic                rx_err
);

  localparam int                DEPTH  = H_PIX * V_PIX;
  localparam int                ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [9:0]        VIS_W10 = 10'(VIS_W);
  localparam logic [9:0]        VIS_H10 = 10'(VIS_H);

  ufb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [3:0]          hi_nib_q, hi_nib_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                rx_err_q, rx_err_d;
  logic                vis_q, vis_d;
  logic                wr_en;
  rgb_t                wr_px;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   row_base;
  logic [9:0]          h_vis, v_vis, h_cell, v_cell;
  logic [COLOUR_W-1:0] rd_dat;

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    hi_nib_d     = hi_nib_q;
    frame_done_d = 1'b0;
    rx_err_d     = 1'b0;
    wr_en        = 1'b0;
    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d   = WAIT_HI;
            wr_addr_d = '0;
          end
        end
        WAIT_HI: begin
          if (rx_data == SYNC_BYTE) begin
            wr_addr_d = '0;
          end else if (rx_data[7:4] == 4'h0) begin
            hi_nib_d = rx_data[3:0];
            state_d  = WAIT_LO;
          end else begin
            rx_err_d = 1'b1;
            state_d  = IDLE;
          end
        end
        WAIT_LO: begin
          // Low byte is pure payload; a 0xA5 here is colour data, not a sync.
          wr_en = 1'b1;
          if (wr_addr_q == LAST) begin
            frame_done_d = 1'b1;
            wr_addr_d    = '0;
            state_d      = IDLE;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
            state_d   = WAIT_HI;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    wr_px.r = hi_nib_q;
    wr_px.g = rx_data[7:4];
    wr_px.b = rx_data[3:0];
  end

  // Counts outside the visible window are zeroed before any address arithmetic.
  always_comb begin
    vis_d  = (h_count < VIS_W10) && (v_count < VIS_H10);
    h_vis  = vis_d ? h_count : '0;
    v_vis  = vis_d ? v_count : '0;
    h_cell = h_vis >> SCALE_SHIFT;
    v_cell = v_vis >> SCALE_SHIFT;
    row_base = '0;
    for (int i = 0; i < 16; i++) begin
      if (H_PIX[i]) begin
        row_base = row_base + (ADDR_W'(v_cell) << i);
      end
    end
    rd_addr = row_base + ADDR_W'(h_cell);
  end

  frame_ram #(
    .DEPTH (DEPTH),
    .AW    (ADDR_W),
    .DW    (COLOUR_W)
  ) u_frame_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr_q),
    .wr_dat  (COLOUR_W'(wr_px)),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_addr_q    <= '0;
      hi_nib_q     <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rx_err_q     <= 1'b0;
      vis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      hi_nib_q     <= hi_nib_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      rx_err_q     <= rx_err_d;
      vis_q        <= vis_d;
    end
  end

`ifdef UFB_TEST_PATTERN_EN
  logic                show_ram_q, show_ram_d;
  logic [COLOUR_W-1:0] pat_q, pat_d;

  always_comb begin
    show_ram_d = show_ram_q | frame_done_d;
    pat_d      = vis_d ? COLOUR_W'(bar_colour(h_count[9:7])) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      show_ram_q <= 1'b0;
      pat_q      <= '0;
    end else begin
      show_ram_q <= show_ram_d;
      pat_q      <= pat_d;
    end
  end

  assign rgb_colour = show_ram_q ? (vis_q ? rd_dat : '0) : pat_q;
`else
  assign rgb_colour = vis_q ? rd_dat : '0;
`endif

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign rx_err     = rx_err_q;

endmodule

// File: tb/tb_uart_frame_buffer.sv
// Directed + randomized bench for uart_frame_buffer against a protocol-level reference model.
module tb_uart_frame_buffer;

  localparam int NPIX = 160 * 120;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [9:0]  h_count = 10'd0;
  logic [9:0]  v_count = 10'd0;
  logic [11:0] rgb_colour;
  logic        busy, frame_done, rx_err;

  uart_frame_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .h_count    (h_count),
    .v_count    (v_count),
    .rgb_colour (rgb_colour),
    .busy       (busy),
    .frame_done (frame_done),
    .rx_err     (rx_err)
  );

  always #5 clk = ~clk;

  // Reference model: protocol position, pending red nibble, stored image.
  logic [11:0] ref_mem [NPIX];
  int          m_phase;   // 0 = hunting for sync, 1 = expect high byte, 2 = expect low byte
  int          m_addr;
  logic [3:0]  m_red;
  bit          m_shown;
  bit          exp_err, exp_done, exp_busy;
  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_addr  = 0;
    m_red   = 4'h0;
    m_shown = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_err  = 1'b0;
    exp_done = 1'b0;
    if (m_phase == 2) begin
      ref_mem[m_addr] = {m_red, b};
      if (m_addr == NPIX - 1) begin
        exp_done = 1'b1;
        m_shown  = 1'b1;
        m_addr   = 0;
        m_phase  = 0;
      end else begin
        m_addr++;
        m_phase = 1;
      end
    end else if (b == 8'hA5) begin
      m_phase = 1;
      m_addr  = 0;
    end else if (m_phase == 1) begin
      if (b < 8'h10) begin
        m_red   = b[3:0];
        m_phase = 2;
      end else begin
        exp_err = 1'b1;
        m_phase = 0;
      end
    end
    exp_busy = (m_phase != 0);
  endtask

  function automatic logic [11:0] bars(input int h);
    logic [2:0] bar;
    bar = 3'(h / 128);
    return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
  endfunction

  function automatic logic [11:0] exp_px(input int h, input int v);
    if (h >= 640 || v >= 480) return 12'h000;
`ifdef UFB_TEST_PATTERN_EN
    if (!m_shown) return bars(h);
`endif
    return ref_mem[(v / 4) * 160 + h / 4];
  endfunction

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    model_byte(b);
    chk("busy", busy, exp_busy);
    chk("rx_err", rx_err, exp_err);
    chk("frame_done", frame_done, exp_done);
    if (frame_done === 1'b1) done_cnt++;
  endtask

  task automatic send_px(input logic [3:0] r, input logic [7:0] gb);
    send({4'h0, r});
    send(gb);
  endtask

  task automatic read_px(input string tag, input int h, input int v);
    h_count = 10'(h);
    v_count = 10'(v);
    @(negedge clk);
    chk(tag, rgb_colour, exp_px(h, v));
  endtask

  initial begin
    logic [11:0] old;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", rx_err, 0);
    chk("rst_rgb", rgb_colour, 0);
    reset = 1'b1;
    @(negedge clk);

`ifdef UFB_TEST_PATTERN_EN
    read_px("pat_130_10", 130, 10);
    chk("pat_const", rgb_colour, 12'h00F);
    read_px("pat_700", 700, 10);
    for (int i = 0; i < 40; i++) read_px("pat_rand", $urandom_range(0, 799), $urandom_range(0, 524));
`endif

    // Full randomized frame, last pixel fixed, occasional idle gaps
    send(8'hA5);
    for (int i = 0; i < NPIX; i++) begin
      if (i == NPIX - 1) send_px(4'hF, 8'hFF);
      else send_px(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 15) == 0) @(negedge clk);
    end
    chk("done_count", done_cnt, 1);
    read_px("last_px", 636, 476);
    chk("last_px_const", rgb_colour, 12'hFFF);
    for (int i = 0; i < 300; i++) read_px("rand_rd", $urandom_range(0, 639), $urandom_range(0, 479));
    read_px("edge_639_479", 639, 479);
    read_px("outside_h640", 640, 0);
    read_px("outside_v480", 0, 480);
    read_px("outside_max", 1023, 1023);

    // First pixel of a new frame covers display 4x4 block
    send(8'hA5);
    send_px(4'h3, 8'h4C);
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 4; h++) read_px("blk0", h, v);
    chk("blk0_const", rgb_colour, 12'h34C);
    read_px("blk1_old", 4, 0);

    // Resync in WAIT_HI, plus read-first collision at addr 0
    send(8'hA5);
    send(8'h07);
    h_count = 10'd0;
    v_count = 10'd0;
    old = ref_mem[0];
    send(8'h12);
    chk("read_first_old", rgb_colour, old);
    @(negedge clk);
    chk("read_first_new", rgb_colour, exp_px(0, 0));
    send(8'hA5);
    send_px(4'h1, 8'h23);
    read_px("resync_px0", 0, 0);
    chk("resync_const", rgb_colour, 12'h123);

    // Protocol error drops to IDLE; following bytes are ignored
    send(8'hA5);
    send(8'h5A);
    send_px(4'h0, 8'h00);
    read_px("err_px0", 0, 0);
    read_px("err_px1", 4, 0);

    // Reset mid-frame
    send(8'hA5);
    for (int i = 0; i < 100; i++) send_px(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    send(8'h0B);
    reset   = 1'b0;
    h_count = 10'd0;
    v_count = 10'd0;
    model_reset();
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rgb", rgb_colour, 0);
    chk("mid_rst_err", rx_err, 0);
    reset = 1'b1;
    @(negedge clk);
    send_px(4'h0, 8'h00);
    chk("post_rst_busy", busy, 0);
    for (int i = 0; i < 100; i++) read_px("kept_px", (i % 160) * 4, (i / 160) * 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
